brief_scheduler: RTL and testbench

- Sits between the FAST corner detector and the BRIEF filter datapath.
- FAST produces corner events as a non-stallable stream. This block buffers each event (coordinates plus its 29-pixel patch) in a small FIFO.
- It presents one event at a time to the BRIEF filter with a one-cycle isCorner strobe, registers the resulting descriptor, and hands it to the Hamming matcher over a valid/ready interface.
- Overflow events are dropped and counted.

---
 rtl/brief_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_brief_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brief_scheduler.sv
// rtl/brief_scheduler.sv - event FIFO and issue/hold sequencer between FAST corners and the BRIEF filter
// Events are queued as {x, y, patch}; each is presented to the filter for one cycle, then held for the matcher.

module brief_scheduler_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // One extra pointer bit distinguishes full from empty when the indices match.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop)  rd_ptr <= rd_ptr + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
endmodule

module brief_scheduler #(
  parameter int IMAGE_BITS = 4,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 10,
  parameter int PATTERN    = 120,
  parameter int NUM_PIX    = 29,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [X_WIDTH-1:0]            in_x,
  input  logic [Y_WIDTH-1:0]            in_y,
  input  logic [NUM_PIX*IMAGE_BITS-1:0] in_patch,
  output logic                          bf_isCorner,
  output logic [X_WIDTH-1:0]            bf_x,
  output logic [Y_WIDTH-1:0]            bf_y,
  output logic [NUM_PIX*IMAGE_BITS-1:0] bf_patch,
  input  logic [PATTERN-1:0]            bf_descriptor,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [X_WIDTH-1:0]            out_x,
  output logic [Y_WIDTH-1:0]            out_y,
  output logic [PATTERN-1:0]            out_desc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          drop_count,
  input  logic                          clear_stats
);
  localparam int PW = NUM_PIX * IMAGE_BITS;
  localparam int EW = X_WIDTH + Y_WIDTH + PW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            pop;
  logic            capture;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            drop;
  logic [EW-1:0]   head;

  // Fullness is the start-of-cycle view, so a pop in the same cycle never rescues a push.
  assign push = in_valid && !fifo_full;
  assign drop = in_valid && fifo_full;

  brief_scheduler_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({in_x, in_y, in_patch}),
    .pop       (pop),
    .pop_data  (head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        capture    = 1'b1;
        next_state = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_state = ISSUE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      bf_isCorner <= 1'b0;
      bf_x        <= '0;
      bf_y        <= '0;
      bf_patch    <= '0;
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      out_desc    <= '0;
    end else begin
      state       <= next_state;
      bf_isCorner <= (next_state == ISSUE);
      if (pop) begin
        {bf_x, bf_y, bf_patch} <= head;
      end
      // The filter output is only meaningful while isCorner is high.
      if (capture) begin
        out_valid <= 1'b1;
        out_x     <= bf_x;
        out_y     <= bf_y;
        out_desc  <= bf_descriptor;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (clear_stats) begin
      drop_count <= '0;
    end else if (drop && (drop_count != {CNT_WIDTH{1'b1}})) begin
      drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_brief_scheduler.sv
// tb/tb_brief_scheduler.sv - vector table, corner sequences and random run against a queue-based reference model
module tb_brief_scheduler;
  typedef struct packed {
    logic [9:0]   x;
    logic [9:0]   y;
    logic [115:0] patch;
  } ev_t;

  typedef struct {
    logic       r;
    logic       iv;
    logic [9:0] x;
    logic [9:0] y;
    logic       rdy;
    logic       clr;
    int         lvl;
    logic       ov;
    logic       isc;
    int         drp;
    logic [9:0] ox;
    logic [9:0] oy;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [9:0]   in_x;
  logic [9:0]   in_y;
  logic [115:0] in_patch;
  logic         bf_isCorner;
  logic [9:0]   bf_x;
  logic [9:0]   bf_y;
  logic [115:0] bf_patch;
  logic [119:0] bf_descriptor;
  logic         out_valid;
  logic         out_ready;
  logic [9:0]   out_x;
  logic [9:0]   out_y;
  logic [119:0] out_desc;
  logic [3:0]   fifo_level;
  logic [15:0]  drop_count;
  logic         clear_stats;

  logic         s_isc;
  logic [9:0]   s_bx;
  logic [9:0]   s_by;
  logic [115:0] s_bp;
  logic         s_ov;
  logic [9:0]   s_ox;
  logic [9:0]   s_oy;
  logic [119:0] s_od;
  logic [3:0]   s_lvl;
  logic [1:0]   s_drop;

  logic [127:0] junk;

  brief_scheduler dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_patch(in_patch),
    .bf_isCorner(bf_isCorner), .bf_x(bf_x), .bf_y(bf_y), .bf_patch(bf_patch),
    .bf_descriptor(bf_descriptor), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_desc(out_desc), .fifo_level(fifo_level),
    .drop_count(drop_count), .clear_stats(clear_stats)
  );

  brief_scheduler #(.CNT_WIDTH(2)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_patch(in_patch),
    .bf_isCorner(s_isc), .bf_x(s_bx), .bf_y(s_by), .bf_patch(s_bp),
    .bf_descriptor(bf_descriptor), .out_valid(s_ov), .out_ready(out_ready),
    .out_x(s_ox), .out_y(s_oy), .out_desc(s_od), .fifo_level(s_lvl),
    .drop_count(s_drop), .clear_stats(clear_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) junk <= {$urandom, $urandom, $urandom, $urandom};

  function automatic logic [119:0] desc_f(input logic [9:0] x, input logic [9:0] y, input logic [115:0] p);
    logic [3:0] t;
    t = x[3:0] ^ y[3:0];
    return {t, p} ^ {x, y, 100'd0};
  endfunction

  // Filter stand-in: real descriptor only while isCorner is high, noise otherwise.
  always_comb begin
    bf_descriptor = junk[119:0];
    if (bf_isCorner) bf_descriptor = desc_f(bf_x, bf_y, bf_patch);
  end

  function automatic ev_t mk_ev(input logic [9:0] x, input logic [9:0] y);
    ev_t e;
    logic [119:0] t;
    t = {6{x, y}};
    e.x = x;
    e.y = y;
    e.patch = t[115:0] ^ {29{4'h5}};
    return e;
  endfunction

  function automatic ev_t rnd_ev();
    ev_t e;
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    e.x = 10'($urandom);
    e.y = 10'($urandom);
    e.patch = r[115:0];
    return e;
  endfunction

  function automatic vec_t mkv(input logic r, iv, input logic [9:0] x, y, input logic rdy, clr,
                               input int lvl, input logic ov, isc, input int drp,
                               input logic [9:0] ox, oy);
    vec_t v;
    v.r = r; v.iv = iv; v.x = x; v.y = y; v.rdy = rdy; v.clr = clr;
    v.lvl = lvl; v.ov = ov; v.isc = isc; v.drp = drp; v.ox = ox; v.oy = oy;
    return v;
  endfunction

  // Reference model: buffered events, the event at the filter, the presented result.
  ev_t          q[$];
  int           ph;
  logic         m_isc;
  ev_t          m_bf;
  logic         m_ov;
  logic [9:0]   m_ox;
  logic [9:0]   m_oy;
  logic [119:0] m_od;
  int           ndrop;

  int total;
  int bad;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic iv, input ev_t ev, input logic rdy, input logic clr);
    int  pre;
    bit  full;
    bit  do_pop;
    if (!r) begin
      q.delete();
      ph = 0; m_isc = 1'b0; m_bf = '0; m_ov = 1'b0; m_ox = '0; m_oy = '0; m_od = '0; ndrop = 0;
    end else begin
      pre = q.size();
      full = (pre == 8);
      do_pop = 1'b0;
      case (ph)
        0: if (pre > 0) begin do_pop = 1'b1; ph = 1; end
        1: begin
          m_ov = 1'b1; m_ox = m_bf.x; m_oy = m_bf.y; m_od = desc_f(m_bf.x, m_bf.y, m_bf.patch);
          ph = 2;
        end
        default: if (rdy) begin
          m_ov = 1'b0;
          if (pre > 0) begin do_pop = 1'b1; ph = 1; end
          else ph = 0;
        end
      endcase
      if (do_pop) m_bf = q.pop_front();
      m_isc = (ph == 1);
      if (iv) begin
        if (full) ndrop++;
        else q.push_back(ev);
      end
      if (clr) ndrop = 0;
    end
  endtask

  task automatic check_all();
    chk("isCorner", 128'(bf_isCorner), 128'(m_isc));
    chk("bf_x", 128'(bf_x), 128'(m_bf.x));
    chk("bf_y", 128'(bf_y), 128'(m_bf.y));
    chk("bf_patch", 128'(bf_patch), 128'(m_bf.patch));
    chk("out_valid", 128'(out_valid), 128'(m_ov));
    chk("out_x", 128'(out_x), 128'(m_ox));
    chk("out_y", 128'(out_y), 128'(m_oy));
    chk("out_desc", 128'(out_desc), 128'(m_od));
    chk("fifo_level", 128'(fifo_level), 128'(q.size()));
    chk("drop_count", 128'(drop_count), 128'((ndrop > 65535) ? 65535 : ndrop));
    chk("drop_small", 128'(s_drop), 128'((ndrop > 3) ? 3 : ndrop));
  endtask

  task automatic step(input logic r, input logic iv, input ev_t ev, input logic rdy, input logic clr);
    reset = r; in_valid = iv; in_x = ev.x; in_y = ev.y; in_patch = ev.patch;
    out_ready = rdy; clear_stats = clr;
    @(posedge clk);
    model_edge(r, iv, ev, rdy, clr);
    #1;
    check_all();
  endtask

  vec_t      tbl[22];
  ev_t       e0;
  logic [9:0] got[$];
  logic [119:0] d0;

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_patch = '0;
    out_ready = 1'b0; clear_stats = 1'b0;
    e0 = '0;

    tbl[0] = mkv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mkv(1, 1, 10'h123, 10'h045, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[2] = mkv(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[3] = mkv(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 10'h123, 10'h045);
    tbl[4] = mkv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[5] = mkv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      tbl[6+k] = mkv(1, 1, 10'(10'h200 + k), 10'(10'h100 + k), 0, 0,
                     (k <= 1) ? 1 : ((k > 8) ? 8 : k), (k >= 2), (k == 1),
                     (k >= 9) ? k - 8 : 0, 10'h200, 10'h100);
    end
    tbl[18] = mkv(1, 0, 0, 0, 0, 0, 8, 1, 0, 3, 10'h200, 10'h100);
    tbl[19] = mkv(1, 1, 10'h3ff, 10'h3ff, 1, 0, 7, 0, 1, 4, 0, 0);
    tbl[20] = mkv(1, 0, 0, 0, 1, 0, 7, 1, 0, 4, 10'h201, 10'h101);
    tbl[21] = mkv(1, 0, 0, 0, 1, 0, 6, 0, 1, 4, 0, 0);

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].r, tbl[i].iv, mk_ev(tbl[i].x, tbl[i].y), tbl[i].rdy, tbl[i].clr);
      chk("tbl_level", 128'(fifo_level), 128'(tbl[i].lvl));
      chk("tbl_valid", 128'(out_valid), 128'(tbl[i].ov));
      chk("tbl_isCorner", 128'(bf_isCorner), 128'(tbl[i].isc));
      chk("tbl_drop", 128'(drop_count), 128'(tbl[i].drp));
      if (tbl[i].ov) begin
        chk("tbl_out_x", 128'(out_x), 128'(tbl[i].ox));
        chk("tbl_out_y", 128'(out_y), 128'(tbl[i].oy));
      end
    end
    chk("single_desc_sat_small", 128'(s_drop), 128'(3));
    for (int i = 0; i < 20; i++) step(1, 0, e0, 1, 0);
    chk("drain_level", 128'(fifo_level), 128'(0));

    // Backpressure: three corners held off for ten cycles.
    step(0, 0, e0, 0, 0);
    step(1, 1, mk_ev(10'h301, 10'h011), 0, 0);
    step(1, 1, mk_ev(10'h302, 10'h012), 0, 0);
    step(1, 1, mk_ev(10'h303, 10'h013), 0, 0);
    e0 = mk_ev(10'h301, 10'h011);
    d0 = desc_f(e0.x, e0.y, e0.patch);
    e0 = '0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, e0, 0, 0);
      chk("hold_valid", 128'(out_valid), 128'(1));
      chk("hold_x", 128'(out_x), 128'(10'h301));
      chk("hold_desc", 128'(out_desc), 128'(d0));
    end
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got.push_back(out_x);
      step(1, 0, e0, 1, 0);
    end
    chk("bp_count", 128'(got.size()), 128'(3));
    for (int i = 0; i < got.size(); i++) chk("bp_order", 128'(got[i]), 128'(10'h301 + i));
    chk("bp_drop", 128'(drop_count), 128'(0));

    // Reset while busy: nothing buffered may survive.
    for (int i = 0; i < 4; i++) step(1, 1, rnd_ev(), 0, 0);
    step(1, 0, e0, 0, 0);
    chk("pre_rst_valid", 128'(out_valid), 128'(1));
    step(0, 1, rnd_ev(), 1, 0);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_level", 128'(fifo_level), 128'(0));
    chk("rst_isCorner", 128'(bf_isCorner), 128'(0));
    chk("rst_drop", 128'(drop_count), 128'(0));
    for (int i = 0; i < 6; i++) begin
      step(1, 0, e0, 1, 0);
      chk("rst_no_stale", 128'(out_valid), 128'(0));
    end

    // Counter rules: clear beats a same-cycle drop; small counter saturates.
    for (int i = 0; i < 10; i++) step(1, 1, rnd_ev(), 0, 0);
    chk("cnt_one", 128'(drop_count), 128'(1));
    step(1, 1, rnd_ev(), 0, 1);
    chk("clr_drop", 128'(drop_count), 128'(0));
    chk("clr_drop_small", 128'(s_drop), 128'(0));
    for (int i = 0; i < 5; i++) step(1, 1, rnd_ev(), 0, 0);
    chk("sat_small", 128'(s_drop), 128'(3));
    chk("five_main", 128'(drop_count), 128'(5));

    // Random traffic with a varying readiness bias.
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 200) % 4;
      step(($urandom_range(0, 399) != 0), 1'($urandom_range(0, 1)), rnd_ev(),
           ($urandom_range(0, 3) < bias), ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
